// File: rtl/framebuffer_pkg.sv
// Shared framebuffer address map, frame geometry and reader FSM encodings.
// Imported by the scanout reader and by the pixel writer.
package framebuffer_pkg;

  localparam logic [28:0] WORDS_PER_FRAME    = 29'h0002_5800;
  localparam logic [28:0] FRAMEBUFFER1_START = 29'h0700_0000;
  localparam logic [28:0] FRAMEBUFFER1_END   = FRAMEBUFFER1_START + WORDS_PER_FRAME - 29'd1;
  localparam logic [28:0] FRAMEBUFFER2_START = 29'h0702_5800;
  localparam logic [28:0] FRAMEBUFFER2_END   = FRAMEBUFFER2_START + WORDS_PER_FRAME - 29'd1;
  localparam int          WIDTH_OFFSET       = 640;
  localparam int          FB_WORD_W          = 64;

  typedef enum logic [3:0] {
    IDLE    = 4'h0,
    REQUEST = 4'h1,
    HOLD    = 4'h2,
    DRAIN   = 4'h3
  } fb_read_state_t;

endpackage

// File: rtl/scanout_fifo.sv
// Single-clock first-word-fall-through FIFO for returned framebuffer words.
// A word pushed in cycle N is on pop_data in cycle N+1. Push and pop in the
// same cycle are legal at any fill level; reset flushes the contents.
module scanout_fifo
  import framebuffer_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = FB_WORD_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !reset;
  assign do_pop   = pop && (count_q != '0);
  assign pop_data = mem[rd_ptr];
  assign valid    = (count_q != '0);
  assign count    = count_q;

  // Storage array; no reset needed, occupancy is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; at full, a simultaneous pop frees the slot being written.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // The reader's credit scheme must never let a push land on a full FIFO.
  always_ff @(posedge clock) begin
    if (!reset) begin
      overflow_check : assert (!(do_push && !do_pop && (count_q == CW'(DEPTH))));
    end
  end

endmodule

// File: rtl/framebuffer_read.sv
// Scanout-side framebuffer reader: fetches one frame from the selected DDR3
// buffer with credit-limited Avalon-MM burst reads and streams the returned
// words out of a local FIFO.
// Optional build macro FRAMEBUFFER_READ_UNDERFLOW_EN adds underflow_count,
// a saturating count of cycles where the consumer was starved mid-fetch.
module framebuffer_read #(
  parameter logic [28:0] FRAMEBUFFER1_START = framebuffer_pkg::FRAMEBUFFER1_START,
  parameter logic [28:0] FRAMEBUFFER2_START = framebuffer_pkg::FRAMEBUFFER2_START,
  parameter logic [28:0] WORDS_PER_FRAME    = framebuffer_pkg::WORDS_PER_FRAME,
  parameter int          BURST_LEN          = 8,
  parameter int          FIFO_DEPTH         = 64
) (
  input  logic        clock,
  input  logic        reset,
  output logic [28:0] address,
  output logic [7:0]  burstcount,
  output logic        read,
  input  logic        waitrequest,
  input  logic [63:0] readdata,
  input  logic        readdatavalid,
  input  logic        buffer,
  input  logic        frame_start,
  output logic        reading_done,
  output logic [63:0] pixel_data,
  output logic        pixel_data_valid,
  input  logic        pixel_data_ready,
  output logic [3:0]  state
`ifdef FRAMEBUFFER_READ_UNDERFLOW_EN
  ,
  output logic [15:0] underflow_count
`endif
);

  import framebuffer_pkg::fb_read_state_t;
  import framebuffer_pkg::IDLE;
  import framebuffer_pkg::REQUEST;
  import framebuffer_pkg::HOLD;
  import framebuffer_pkg::DRAIN;

  // state   | meaning
  // IDLE    | waiting for frame_start; buffer is sampled here
  // REQUEST | waiting for enough FIFO credit to issue the next burst
  // HOLD    | burst presented on the bus, held until waitrequest drops
  // DRAIN   | all bursts accepted, waiting for the last words to return

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 2;

  fb_read_state_t state_q, state_d;
  logic [28:0]    base_q, base_d;
  logic [28:0]    issued_q, issued_d;
  logic [28:0]    address_q, address_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] fifo_count;
  logic [SUM_W-1:0] committed;
  logic             credit_ok;
  logic             accept;
  logic             pop;

  // Credit holds when the FIFO can absorb this burst on top of everything already
  // stored or still in flight, so returned data never needs backpressure.
  assign committed  = SUM_W'(fifo_count) + SUM_W'(outstanding_q) + SUM_W'(BURST_LEN);
  assign credit_ok  = (committed <= SUM_W'(FIFO_DEPTH));
  assign accept     = (state_q == HOLD) && !waitrequest;
  assign pop        = pixel_data_valid && pixel_data_ready;

  assign read       = (state_q == HOLD);
  assign address    = address_q;
  assign burstcount = 8'(BURST_LEN);
  assign state      = state_q;

  // Next-state and burst bookkeeping.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    issued_d     = issued_q;
    address_d    = address_q;
    reading_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          base_d   = buffer ? FRAMEBUFFER1_START : FRAMEBUFFER2_START;
          issued_d = '0;
          state_d  = REQUEST;
        end
      end
      REQUEST: begin
        if (credit_ok) begin
          address_d = base_q + issued_q;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (!waitrequest) begin
          issued_d = issued_q + 29'(BURST_LEN);
          state_d  = (issued_d == WORDS_PER_FRAME) ? DRAIN : REQUEST;
        end
      end
      DRAIN: begin
        if (outstanding_q == '0) begin
          reading_done = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Words requested but not yet returned; acceptance and a return may coincide.
  always_comb begin
    outstanding_d = outstanding_q;
    if (accept) begin
      outstanding_d = outstanding_d + CNT_W'(BURST_LEN);
    end
    if (readdatavalid) begin
      outstanding_d = outstanding_d - CNT_W'(1);
    end
  end

  // State and bookkeeping registers; reset abandons any fetch in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      base_q        <= '0;
      issued_q      <= '0;
      address_q     <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      issued_q      <= issued_d;
      address_q     <= address_d;
      outstanding_q <= outstanding_d;
    end
  end

  scanout_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (readdatavalid),
    .push_data (readdata),
    .pop       (pop),
    .pop_data  (pixel_data),
    .valid     (pixel_data_valid),
    .count     (fifo_count)
  );

`ifdef FRAMEBUFFER_READ_UNDERFLOW_EN
  logic [15:0] underflow_q;

  assign underflow_count = underflow_q;

  // Count starved consumer cycles during a fetch; a new frame clears the count.
  always_ff @(posedge clock) begin
    if (reset) begin
      underflow_q <= '0;
    end else if ((state_q == IDLE) && frame_start) begin
      underflow_q <= '0;
    end else if ((state_q != IDLE) && pixel_data_ready && !pixel_data_valid &&
                 (underflow_q != 16'hFFFF)) begin
      underflow_q <= underflow_q + 16'd1;
    end
  end
`endif

endmodule
